// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states, grant codes, wait-counter width.
// Pure declarations; no logic, no latency.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      GNT_NONE  = 2'd0,
      GNT_FETCH = 2'd1,
      GNT_DATA  = 2'd2,
      GNT_LOAD  = 2'd3
   } gnt_t;

   // Wide enough for RD_LAT-1 with RD_LAT up to 7.
   localparam int CNT_W = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: loader always wins, fetch/data broken by the rr bit.
// Zero latency, no state; the caller decides when the result is used.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic f_req,
   input  logic d_req,
   input  logic l_req,
   input  logic rr,
   output gnt_t winner
);

   always_comb begin
      winner = GNT_NONE;
      if (l_req) begin
         winner = GNT_LOAD;
      end else if (f_req && d_req) begin
         winner = rr ? GNT_DATA : GNT_FETCH;
      end else if (f_req) begin
         winner = GNT_FETCH;
      end else if (d_req) begin
         winner = GNT_DATA;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch, data and loader; IDLE -> ACCESS -> [WAIT x RD_LAT] -> DONE.
// Writes ack 2 cycles after the grant sample, reads 2+RD_LAT; losers simply hold req until served.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 1
)
(
   input  logic              clk,
   input  logic              Reset,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   input  logic              l_req,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_ack,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        grant,
   output logic              busy
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

   state_t            state_q;
   gnt_t              grant_q;
   gnt_t              winner_d;
   logic              rr_q;
   logic              we_q;
   logic              busy_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              f_ack_q;
   logic              d_ack_q;
   logic              l_ack_q;
   logic [DATA_W-1:0] rdata_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              mem_we_q;
   logic              mem_re_q;

   mem_arb_pick u_pick (
      .f_req  (f_req),
      .d_req  (d_req),
      .l_req  (l_req),
      .rr     (rr_q),
      .winner (winner_d)
   );

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q     <= ST_IDLE;
         grant_q     <= GNT_NONE;
         rr_q        <= 1'b0;
         we_q        <= 1'b0;
         busy_q      <= 1'b0;
         cnt_q       <= '0;
         f_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         l_ack_q     <= 1'b0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
      end else begin
         // Strobes and acks are single-cycle pulses unless re-asserted below.
         f_ack_q  <= 1'b0;
         d_ack_q  <= 1'b0;
         l_ack_q  <= 1'b0;
         mem_we_q <= 1'b0;
         mem_re_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (winner_d != GNT_NONE) begin
                  grant_q <= winner_d;
                  busy_q  <= 1'b1;
                  state_q <= ST_ACCESS;
                  case (winner_d)
                     GNT_LOAD: begin
                        mem_addr_q  <= l_addr;
                        mem_wdata_q <= l_wdata;
                        we_q        <= 1'b1;
                        mem_we_q    <= 1'b1;
                     end
                     GNT_FETCH: begin
                        mem_addr_q <= f_addr;
                        we_q       <= 1'b0;
                        mem_re_q   <= 1'b1;
                        rr_q       <= 1'b1;
                     end
                     GNT_DATA: begin
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        we_q        <= d_we;
                        mem_we_q    <= d_we;
                        mem_re_q    <= ~d_we;
                        rr_q        <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            ST_ACCESS: begin
               if (we_q) begin
                  state_q <= ST_DONE;
                  f_ack_q <= (grant_q == GNT_FETCH);
                  d_ack_q <= (grant_q == GNT_DATA);
                  l_ack_q <= (grant_q == GNT_LOAD);
               end else begin
                  state_q <= ST_WAIT;
                  cnt_q   <= CNT_INIT;
               end
            end
            ST_WAIT: begin
               if (cnt_q == '0) begin
                  rdata_q <= mem_rdata;
                  state_q <= ST_DONE;
                  f_ack_q <= (grant_q == GNT_FETCH);
                  d_ack_q <= (grant_q == GNT_DATA);
                  l_ack_q <= (grant_q == GNT_LOAD);
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_DONE: begin
               grant_q <= GNT_NONE;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign f_ack     = f_ack_q;
   assign d_ack     = d_ack_q;
   assign l_ack     = l_ack_q;
   assign rdata     = rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign mem_re    = mem_re_q;
   assign grant     = grant_q;
   assign busy      = busy_q;

endmodule
